// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the CPU-to-bus bridge: FSM encodings and the
// read data returned when a bus cycle is abandoned.
package bus_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2,
      HOLD = 2'd3
   } state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_bridge_if.sv
// CPU request/response and bus signals of the bridge, bundled with the
// bridge-side (master) and environment-side (slave) views.
interface bus_bridge_if;
   import bus_bridge_pkg::*;

   // CPU side: req_en is a level held until rsp_ack; rsp_ack is a one-cycle
   // pulse. Bus side: W_STB qualifies a cycle and all W_* outputs stay stable
   // until W_ACK is sampled high or the bridge times out.
   logic        req_en;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_thread;
   logic [31:0] rsp_data;
   logic        rsp_ack;
   logic        rsp_err;
   logic [31:0] W_ADDR;
   logic [31:0] W_DATA_O;
   logic        W_WRITE;
   logic        W_STB;
   logic [1:0]  W_TID;
   logic [31:0] W_DATA_I;
   logic        W_ACK;
   state_e      dbg_state;

   modport master (
      input  req_en, req_we, req_addr, req_wdata, req_thread, W_DATA_I, W_ACK,
      output rsp_data, rsp_ack, rsp_err, W_ADDR, W_DATA_O, W_WRITE, W_STB, W_TID,
      output dbg_state
   );

   modport slave (
      output req_en, req_we, req_addr, req_wdata, req_thread, W_DATA_I, W_ACK,
      input  rsp_data, rsp_ack, rsp_err, W_ADDR, W_DATA_O, W_WRITE, W_STB, W_TID,
      input  dbg_state
   );

endinterface

// File: rtl/bus_timer.sv
// 8-bit bus-cycle watchdog: counts enabled cycles and flags the last cycle
// before the count reaches TIMEOUT.
module bus_timer #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 8'd0;
      end else if (en_i) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // The count becomes TIMEOUT on this cycle's edge, so the bus cycle ends here.
   assign tc_o = (count_q == TIMEOUT - 8'd1);

endmodule

// File: rtl/bus_bridge.sv
// Bridges a held CPU request level onto a strobe/acknowledge bus, with a
// bus-cycle timeout and a guard against replaying a still-held request.
module bus_bridge import bus_bridge_pkg::*; #(
   parameter logic [7:0]  TIMEOUT  = 8'd255,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input logic          clk,
   input logic          W_RST,
   bus_bridge_if.master bus
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  tid_q, tid_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic        in_bus;
   logic        tmr_tc;

   assign in_bus = (state_q == BUS);

   bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .rst_i (W_RST),
      .clr_i (!in_bus),
      .en_i  (in_bus && !bus.W_ACK),
      .tc_o  (tmr_tc)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      tid_d   = tid_q;
      we_d    = we_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_en) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               we_d    = bus.req_we;
               tid_d   = bus.req_thread;
               state_d = BUS;
            end
         end
         BUS: begin
            // An acknowledge wins over a timeout landing on the same cycle.
            if (bus.W_ACK) begin
               if (!we_q) rdata_d = bus.W_DATA_I;
               state_d = RESP;
            end else if (tmr_tc) begin
               if (!we_q) rdata_d = ERR_DATA;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: state_d = HOLD;
         HOLD: begin
            // Only a dropped or different request may start another bus cycle.
            if (!bus.req_en || (bus.req_addr != addr_q) || (bus.req_we != we_q)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (W_RST) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         tid_q   <= 2'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         tid_q   <= tid_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   assign bus.W_STB     = in_bus;
   assign bus.W_ADDR    = addr_q;
   assign bus.W_DATA_O  = wdata_q;
   assign bus.W_WRITE   = we_q;
   assign bus.W_TID     = tid_q;
   assign bus.rsp_ack   = (state_q == RESP);
   assign bus.rsp_data  = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge: a negedge monitor checks every bus cycle and
// every rsp_ack against expected queues filled when requests are issued.
module tb_bus_bridge;
   import bus_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst;

   bus_bridge_if bif();

   bus_bridge #(.TIMEOUT(8'd255), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk   (clk),
      .W_RST (rst),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [32:0] exp_rsp_q[$];
   logic [66:0] exp_bus_q[$];
   int ack_count = 0;
   int bus_starts = 0;
   int stb_len = 0;
   int last_stb_len = 0;
   logic stb_prev = 1'b0;
   logic [66:0] cur_bus = '0;

   task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [66:0] bus_now;
      bus_now = {bif.W_ADDR, bif.W_WRITE, bif.W_DATA_O, bif.W_TID};
      if (!rst) begin
         if (bif.W_STB && !stb_prev) begin
            bus_starts++;
            cur_bus = bus_now;
            if (exp_bus_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_bus_cycle: got addr %0h expected no cycle", bif.W_ADDR);
            end else begin
               check("bus_cycle", bus_now, exp_bus_q.pop_front());
            end
         end else if (bif.W_STB) begin
            check("bus_stable", bus_now, cur_bus);
         end
         if (bif.rsp_ack) begin
            ack_count++;
            if (exp_rsp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_rsp_ack: got ack data %0h expected no ack", bif.rsp_data);
            end else begin
               check("rsp", {34'd0, bif.rsp_err, bif.rsp_data}, {34'd0, exp_rsp_q.pop_front()});
            end
         end
      end
      if (bif.W_STB) begin
         stb_len++;
      end else if (stb_prev) begin
         last_stb_len = stb_len;
         stb_len = 0;
      end
      stb_prev = bif.W_STB;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] tid);
      bif.req_en     = 1'b1;
      bif.req_we     = we;
      bif.req_addr   = addr;
      bif.req_wdata  = wdata;
      bif.req_thread = tid;
      exp_bus_q.push_back({addr, we, wdata, tid});
   endtask

   task automatic wait_stb(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!bif.W_STB && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bif.W_STB) begin
         tests++; fails++;
         $display("FAIL %s: got no W_STB within 20 cycles expected strobe", name);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected end of run");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0;
      int b0;
      int n;
      rst = 1'b1;
      bif.req_en = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0;
      bif.req_wdata = '0; bif.req_thread = '0; bif.W_DATA_I = '0; bif.W_ACK = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_addr_wdata", {3'd0, bif.W_ADDR, bif.W_DATA_O}, 67'd0);
      check("rst_rsp_data", 67'(bif.rsp_data), 67'd0);
      check("rst_ctrl", 67'({bif.W_STB, bif.W_WRITE, bif.rsp_ack, bif.rsp_err, bif.W_TID}), 67'd0);
      check("rst_state", 67'(bif.dbg_state), 67'(IDLE));
      tick();
      rst = 1'b0;

      // W_ACK while idle must be ignored
      bif.W_ACK = 1'b1;
      tick(); tick();
      bif.W_ACK = 1'b0;
      @(negedge clk);
      check("idle_ack_ignored", 67'({bif.W_STB, bif.rsp_ack}), 67'd0);

      // Read, acknowledged in the third bus cycle
      tick();
      a0 = ack_count;
      issue(1'b0, 32'h10, 32'h0, 2'd1);
      exp_rsp_q.push_back({1'b0, 32'h1234_5678});
      wait_stb("read");
      tick(); tick();
      bif.W_ACK = 1'b1; bif.W_DATA_I = 32'h1234_5678;
      tick();
      bif.W_ACK = 1'b0; bif.W_DATA_I = '0; bif.req_en = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("read_stb_len", 67'(last_stb_len), 67'd3);
      check("read_ack_count", 67'(ack_count - a0), 67'd1);

      // Write with immediate acknowledge: minimum latency
      tick();
      issue(1'b1, 32'h20, 32'hA5A5_A5A5, 2'd2);
      exp_rsp_q.push_back({1'b0, 32'h1234_5678});
      bif.W_ACK = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("write_ctrl", 67'({bif.W_STB, bif.W_WRITE, bif.rsp_ack}), 67'b110);
      check("write_data", 67'(bif.W_DATA_O), 67'h0A5A5_A5A5);
      @(posedge clk);
      #1;
      bif.W_ACK = 1'b0; bif.req_en = 1'b0;
      @(negedge clk);
      check("write_latency", 67'(bif.rsp_ack), 67'd1);
      repeat (3) tick();

      // Held request: no replay, then address change issues a new cycle
      tick();
      b0 = bus_starts;
      issue(1'b0, 32'h10, 32'h0, 2'd3);
      exp_rsp_q.push_back({1'b0, 32'h0BAD_F00D});
      wait_stb("held_first");
      bif.W_ACK = 1'b1; bif.W_DATA_I = 32'h0BAD_F00D;
      tick();
      bif.W_ACK = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      check("held_no_replay", 67'(bus_starts - b0), 67'd1);
      tick();
      issue(1'b0, 32'h11, 32'h0, 2'd3);
      exp_rsp_q.push_back({1'b0, 32'h1111_1111});
      wait_stb("held_second");
      bif.W_ACK = 1'b1; bif.W_DATA_I = 32'h1111_1111;
      tick();
      bif.W_ACK = 1'b0; bif.req_en = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("held_two_cycles", 67'(bus_starts - b0), 67'd2);

      // Acknowledge on the same cycle the timeout fires
      tick();
      issue(1'b0, 32'h40, 32'h0, 2'd1);
      exp_rsp_q.push_back({1'b0, 32'h5A5A_0001});
      wait_stb("simul");
      repeat (254) @(posedge clk);
      #1;
      bif.W_ACK = 1'b1; bif.W_DATA_I = 32'h5A5A_0001;
      tick();
      bif.W_ACK = 1'b0; bif.req_en = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("simul_stb_len", 67'(last_stb_len), 67'd255);
      check("simul_err", 67'(bif.rsp_err), 67'd0);

      // Read that is never acknowledged
      tick();
      issue(1'b0, 32'h30, 32'h0, 2'd0);
      exp_rsp_q.push_back({1'b1, 32'hDEAD_BEEF});
      wait_stb("timeout");
      n = 0;
      while (bif.W_STB && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bif.W_STB) begin
         tests++; fails++;
         $display("FAIL timeout_drop: got W_STB still high expected drop");
      end
      bif.req_en = 1'b0;
      @(negedge clk);
      check("timeout_stb_len", 67'(last_stb_len), 67'd255);
      repeat (3) tick();
      @(negedge clk);
      check("timeout_err", 67'(bif.rsp_err), 67'd1);
      check("timeout_data", 67'(bif.rsp_data), 67'h0DEAD_BEEF);

      // Later successful write keeps the error flag and the read data
      tick();
      issue(1'b1, 32'h50, 32'h1, 2'd0);
      exp_rsp_q.push_back({1'b1, 32'hDEAD_BEEF});
      bif.W_ACK = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      bif.W_ACK = 1'b0; bif.req_en = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      check("err_sticky", 67'(bif.rsp_err), 67'd1);

      // Reset during the second bus cycle, late acknowledge afterwards
      tick();
      a0 = ack_count;
      issue(1'b0, 32'h60, 32'h0, 2'd2);
      wait_stb("rst_mid");
      tick();
      rst = 1'b1; bif.req_en = 1'b0;
      tick();
      rst = 1'b0;
      bif.W_ACK = 1'b1; bif.W_DATA_I = 32'hFFFF_FFFF;
      @(negedge clk);
      check("rst_mid_addr_wdata", {3'd0, bif.W_ADDR, bif.W_DATA_O}, 67'd0);
      check("rst_mid_ctrl", 67'({bif.W_STB, bif.W_WRITE, bif.rsp_ack, bif.rsp_err, bif.W_TID}), 67'd0);
      check("rst_mid_state", 67'(bif.dbg_state), 67'(IDLE));
      tick();
      bif.W_ACK = 1'b0; bif.W_DATA_I = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_mid_no_ack", 67'(ack_count - a0), 67'd0);
      check("rst_mid_rsp_data", 67'(bif.rsp_data), 67'd0);
      check("rst_mid_stb", 67'(bif.W_STB), 67'd0);

      check("rsp_queue_empty", 67'(exp_rsp_q.size()), 67'd0);
      check("bus_queue_empty", 67'(exp_bus_q.size()), 67'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
